readout_calibration_integrator: RTL and testbench
=================================================

// Module: readout_calibration_integrator
// PURPOSE
// - Receive-side counterpart of the drive IQ calibration path. Takes raw ADC I/Q samples from the
//   readout front end and removes the per-channel DC offset, then applies the inverse IQ-imbalance
//   correction matrix. It integrates the corrected I/Q over a programmable window of valid samples.
// - Hands the integrated pair to the state discriminator over a valid/ready handshake.
// PARAMETERS
// IQ_CALI_WIDTH  9   width of samples and coefficients; signed two's complement, Q1.(W-1)
// ACC_WIDTH      20  width of each signed integration accumulator
// WINDOW_WIDTH   10  width of the window-length register
// PORTS
// clk          in   1              clock
// rst          in   1              asynchronous reset, active-high
// i_in         in   IQ_CALI_WIDTH  raw ADC I sample
// q_in         in   IQ_CALI_WIDTH  raw ADC Q sample
// valid_in     in   1              i_in/q_in valid this cycle
// dc_offset_i  in   IQ_CALI_WIDTH  I DC offset, subtracted from i_in
// dc_offset_q  in   IQ_CALI_WIDTH  Q DC offset, subtracted from q_in
// alpha_i      in   IQ_CALI_WIDTH  I self coefficient
// beta_i       in   IQ_CALI_WIDTH  I-to-Q cross coefficient
// alpha_q      in   IQ_CALI_WIDTH  Q self coefficient
// beta_q       in   IQ_CALI_WIDTH  Q-to-I cross coefficient
// window_len   in   WINDOW_WIDTH   samples per window; latched on start; 0 is treated as 1
// start        in   1              one-cycle pulse that opens a window; honoured only in IDLE
// ready_in     in   1              discriminator ready
// busy         out  1              high in every state except IDLE
// i_acc_out    out  ACC_WIDTH      integrated I; held stable while valid_out is high
// q_acc_out    out  ACC_WIDTH      integrated Q; held stable while valid_out is high
// valid_out    out  1              integrated result available
// overflow     out  1              an accumulator saturated in this window; stays high until the next start
// BEHAVIOUR
// - Reset (async, any state): FSM to IDLE; pipeline valids, counters and accumulators cleared.
//   All outputs 0.
// - Datapath: 3 registered stages; a sample's valid is carried through all 3.
//   * S1: d_i = sat(i_in - dc_offset_i), d_q = sat(q_in - dc_offset_q). The difference is
//     computed at W+1 bits, then saturated to W bits.
//   * S2: the products d_i*alpha_i, d_q*beta_q, d_q*alpha_q and d_i*beta_i. Each is a full
//     2W-bit signed product, arithmetic-shifted right by W-1 and truncated to W bits.
//   * S3: c_i = sat(d_i*alpha_i + d_q*beta_q), c_q = sat(d_q*alpha_q + d_i*beta_i).
//     Each sum is computed at W+1 bits, then saturated to W bits.
//   * A sample accepted at input cycle t reaches the accumulator input at cycle t+3.
// - Accumulate: acc += sign_ext(c) at ACC_WIDTH. On overflow the accumulator saturates to the
//   signed max/min and overflow is set.
// - FSM states:
//   * IDLE: start -> RUN. On entry to RUN, latch N = max(window_len, 1), zero both counters
//     and both accumulators, and clear overflow.
//   * RUN: a sample is accepted when valid_in && in_cnt < N; in_cnt increments on each accepted
//     sample. valid_in is ignored in every other state and once in_cnt == N. When in_cnt reaches
//     N, go to DRAIN.
//   * DRAIN: each accepted sample that exits S3 updates the accumulators and increments out_cnt.
//     This also applies to samples exiting S3 while the FSM is still in RUN. When out_cnt == N,
//     go to DONE and register the accumulators onto i_acc_out/q_acc_out.
//   * DONE: valid_out = 1 and the outputs are held. On valid_out && ready_in, go to IDLE and drop
//     valid_out in the next cycle. i_acc_out/q_acc_out keep their last value in IDLE.
// - Latency: the last accepted sample at cycle t gives valid_out at cycle t+4, provided ready_in
//   does not stall.
// - Minimum window: N = 1, accepted at cycle t, gives valid_out at t+4.
// - start in RUN, DRAIN or DONE is ignored; no queueing.
// - start in the same cycle as the DONE handshake is ignored. Only start seen in IDLE is honoured.
// - Coefficient and offset inputs are sampled every cycle. Changing them mid-window affects only
//   samples entering S1 after the change.
// - Reset mid-window discards partial results. valid_out is not asserted for that window.
// TESTING
// - T1 unity-half gain: alpha_i=alpha_q=9'h080, betas=0, dc=0, window_len=4, 4x (i=100, q=-20)
//   -> i_acc_out=200, q_acc_out=-40, valid_out 4 cycles after the last sample, overflow=0.
// - T2 DC and cross term: dc_offset_i=10, alpha_i=alpha_q=9'h080, beta_q=9'h080,
//   window_len=2, 2x (i=10, q=40) -> i_acc_out=40, q_acc_out=40.
// - T3 saturation: i_in=255, dc_offset_i=-256 -> d_i saturates to 255. Then with ACC_WIDTH=12,
//   alpha_i=9'h0FF, window_len=16 -> i_acc_out=2047, overflow=1; cleared on the next start.
// - T4 gaps and zero window: window_len=0 with a valid_in gap before the sample -> exactly 1
//   sample integrated. A window of 3 with bubbles -> only valid samples are counted.
//   valid_in beyond N -> ignored.
// - T5 backpressure: ready_in=0 for 5 cycles in DONE -> outputs stable, valid_out high, start
//   ignored. ready_in=1 -> IDLE next cycle, busy=0.
// - T6 reset mid-RUN after 2 of 4 samples -> all outputs 0, IDLE. The next start with 4 samples
//   gives a result that excludes the pre-reset samples.

Source files
------------

// File: rtl/readout_calibration_integrator.sv
// Receive-side IQ calibration (DC removal, inverse IQ-imbalance matrix) with windowed integration.
// Last accepted sample at t -> valid_out at t+4; ready_in low holds the result in DONE.
module readout_calibration_integrator #(
   parameter int IQ_CALI_WIDTH = 9,
   parameter int ACC_WIDTH     = 20,
   parameter int WINDOW_WIDTH  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IQ_CALI_WIDTH-1:0] i_in,
   input  logic [IQ_CALI_WIDTH-1:0] q_in,
   input  logic                     valid_in,
   input  logic [IQ_CALI_WIDTH-1:0] dc_offset_i,
   input  logic [IQ_CALI_WIDTH-1:0] dc_offset_q,
   input  logic [IQ_CALI_WIDTH-1:0] alpha_i,
   input  logic [IQ_CALI_WIDTH-1:0] beta_i,
   input  logic [IQ_CALI_WIDTH-1:0] alpha_q,
   input  logic [IQ_CALI_WIDTH-1:0] beta_q,
   input  logic [WINDOW_WIDTH-1:0]  window_len,
   input  logic                     start,
   input  logic                     ready_in,
   output logic                     busy,
   output logic [ACC_WIDTH-1:0]     i_acc_out,
   output logic [ACC_WIDTH-1:0]     q_acc_out,
   output logic                     valid_out,
   output logic                     overflow
);
   localparam int W = IQ_CALI_WIDTH;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic logic [W-1:0] sat_w(input logic [W:0] x);
      if (x[W] != x[W-1]) return {x[W], {(W-1){~x[W]}}};
      return x[W-1:0];
   endfunction

   function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] p;
      p = (2*W)'($signed(a)) * (2*W)'($signed(b));
      return W'(p >>> (W-1));
   endfunction

   // Returns {saturated_flag, new_accumulator}.
   function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a, input logic [W-1:0] c);
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-W){c[W-1]}}, c};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
      return {1'b0, s[ACC_WIDTH-1:0]};
   endfunction

   logic [1:0]              state_q, state_d;
   logic [WINDOW_WIDTH-1:0] n_q, n_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic                    v1_q, v2_q, v3_q, accept;
   logic [W-1:0]            d_i_q, d_q_q, d_i_d, d_q_d;
   logic [W-1:0]            ai_q, bi_q, aq_q, bq_q;
   logic [W-1:0]            p_ia_q, p_qb_q, p_qa_q, p_ib_q;
   logic [W-1:0]            p_ia_d, p_qb_d, p_qa_d, p_ib_d;
   logic [W-1:0]            c_i_q, c_q_q, c_i_d, c_q_d;
   logic [ACC_WIDTH-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [ACC_WIDTH-1:0]    out_i_q, out_i_d, out_q_q, out_q_d;
   logic [ACC_WIDTH:0]      add_i, add_q;
   logic                    ovf_q, ovf_d;

   assign accept = (state_q == ST_RUN) && valid_in && (in_cnt_q < n_q);

   // Coefficients travel with the sample from S1 so mid-window changes only hit later samples.
   always_comb begin
      d_i_d  = sat_w({i_in[W-1], i_in} - {dc_offset_i[W-1], dc_offset_i});
      d_q_d  = sat_w({q_in[W-1], q_in} - {dc_offset_q[W-1], dc_offset_q});
      p_ia_d = qmul(d_i_q, ai_q);
      p_qb_d = qmul(d_q_q, bq_q);
      p_qa_d = qmul(d_q_q, aq_q);
      p_ib_d = qmul(d_i_q, bi_q);
      c_i_d  = sat_w({p_ia_q[W-1], p_ia_q} + {p_qb_q[W-1], p_qb_q});
      c_q_d  = sat_w({p_qa_q[W-1], p_qa_q} + {p_ib_q[W-1], p_ib_q});
      add_i  = acc_add(acc_i_q, c_i_q);
      add_q  = acc_add(acc_q_q, c_q_q);
   end

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      acc_i_d   = acc_i_q;
      acc_q_d   = acc_q_q;
      ovf_d     = ovf_q;
      out_i_d   = out_i_q;
      out_q_d   = out_q_q;
      if (v3_q && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
         acc_i_d   = add_i[ACC_WIDTH-1:0];
         acc_q_d   = add_q[ACC_WIDTH-1:0];
         ovf_d     = ovf_q | add_i[ACC_WIDTH] | add_q[ACC_WIDTH];
         out_cnt_d = out_cnt_q + 1'b1;
      end
      case (state_q)
         ST_IDLE: if (start) begin
            state_d   = ST_RUN;
            n_d       = (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            acc_i_d   = '0;
            acc_q_d   = '0;
            ovf_d     = 1'b0;
         end
         ST_RUN: if (accept) begin
            in_cnt_d = in_cnt_q + 1'b1;
            if (in_cnt_d == n_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (out_cnt_d == n_q) begin
            state_d = ST_DONE;
            out_i_d = acc_i_d;
            out_q_d = acc_q_d;
         end
         default: if (ready_in) state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         n_q <= '0;       in_cnt_q <= '0;  out_cnt_q <= '0;
         v1_q <= 1'b0;    v2_q <= 1'b0;    v3_q <= 1'b0;
         d_i_q <= '0;     d_q_q <= '0;
         ai_q <= '0;      bi_q <= '0;      aq_q <= '0;     bq_q <= '0;
         p_ia_q <= '0;    p_qb_q <= '0;    p_qa_q <= '0;   p_ib_q <= '0;
         c_i_q <= '0;     c_q_q <= '0;
         acc_i_q <= '0;   acc_q_q <= '0;   ovf_q <= 1'b0;
         out_i_q <= '0;   out_q_q <= '0;
      end else begin
         state_q <= state_d;
         n_q <= n_d;      in_cnt_q <= in_cnt_d;  out_cnt_q <= out_cnt_d;
         v1_q <= accept;  v2_q <= v1_q;  v3_q <= v2_q;
         d_i_q <= d_i_d;  d_q_q <= d_q_d;
         ai_q <= alpha_i; bi_q <= beta_i; aq_q <= alpha_q; bq_q <= beta_q;
         p_ia_q <= p_ia_d; p_qb_q <= p_qb_d; p_qa_q <= p_qa_d; p_ib_q <= p_ib_d;
         c_i_q <= c_i_d;  c_q_q <= c_q_d;
         acc_i_q <= acc_i_d; acc_q_q <= acc_q_d; ovf_q <= ovf_d;
         out_i_q <= out_i_d; out_q_q <= out_q_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign valid_out = (state_q == ST_DONE);
   assign i_acc_out = out_i_q;
   assign q_acc_out = out_q_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_readout_calibration_integrator.sv
// Directed bench for readout_calibration_integrator; a second instance with ACC_WIDTH=12 covers saturation.
module tb_readout_calibration_integrator;
   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  i_in, q_in, dc_i, dc_q, a_i, b_i, a_q, b_q;
   logic        valid_in, start, ready_in;
   logic [9:0]  window_len;
   logic        busy, valid_out, overflow;
   logic [19:0] i_acc, q_acc;
   logic        busy12, valid12, ovf12;
   logic [11:0] i12, q12;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   readout_calibration_integrator dut (
      .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
      .dc_offset_i(dc_i), .dc_offset_q(dc_q), .alpha_i(a_i), .beta_i(b_i),
      .alpha_q(a_q), .beta_q(b_q), .window_len(window_len), .start(start),
      .ready_in(ready_in), .busy(busy), .i_acc_out(i_acc), .q_acc_out(q_acc),
      .valid_out(valid_out), .overflow(overflow));

   readout_calibration_integrator #(.ACC_WIDTH(12)) dut12 (
      .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
      .dc_offset_i(dc_i), .dc_offset_q(dc_q), .alpha_i(a_i), .beta_i(b_i),
      .alpha_q(a_q), .beta_q(b_q), .window_len(window_len), .start(start),
      .ready_in(ready_in), .busy(busy12), .i_acc_out(i12), .q_acc_out(q12),
      .valid_out(valid12), .overflow(ovf12));

   task automatic set_cal(input logic [8:0] dci, dcq, ai, bi, aq, bq);
      dc_i = dci; dc_q = dcq; a_i = ai; b_i = bi; a_q = aq; b_q = bq;
   endtask

   task automatic start_win(input logic [9:0] len);
      window_len = len; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [8:0] i, input logic [8:0] q);
      i_in = i; q_in = q; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (valid_out !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (valid_out !== 1'b1) begin
         errors++; $display("FAIL wait_done: valid_out=%b after %0d cycles, required 1", valid_out, lat);
      end
   endtask

   task automatic release_result;
      ready_in = 1'b1;
      @(negedge clk);
      ready_in = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, valid_out, overflow} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: busy/valid/ovf=%b required 000", {busy, valid_out, overflow});
      end
      checks++;
      if (i_acc !== 20'd0 || q_acc !== 20'd0) begin
         errors++; $display("FAIL reset_acc: i=%0d q=%0d required 0 0", $signed(i_acc), $signed(q_acc));
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unity_gain;
      int lat;
      set_cal(9'h000, 9'h000, 9'h080, 9'h000, 9'h080, 9'h000);
      ready_in = 1'b1;
      start_win(10'd4);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: busy=%b required 1", busy); end
      for (int k = 0; k < 4; k++) send(9'sd100, -9'sd20);
      wait_done(lat);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL t1_latency: %0d cycles, required 4", lat); end
      checks++;
      if ($signed(i_acc) !== 20'sd200 || $signed(q_acc) !== -20'sd40) begin
         errors++; $display("FAIL t1_acc: i=%0d q=%0d required 200 -40", $signed(i_acc), $signed(q_acc));
      end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL t1_ovf: overflow=%b required 0", overflow); end
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || busy !== 1'b0 || $signed(i_acc) !== 20'sd200) begin
         errors++; $display("FAIL t1_after_hs: valid=%b busy=%b i=%0d required 0 0 200", valid_out, busy, $signed(i_acc));
      end
      ready_in = 1'b0;
   endtask

   task automatic test_dc_cross;
      int lat;
      set_cal(9'd10, 9'h000, 9'h080, 9'h000, 9'h080, 9'h080);
      start_win(10'd2);
      for (int k = 0; k < 2; k++) send(9'sd10, 9'sd40);
      wait_done(lat);
      checks++;
      if ($signed(i_acc) !== 20'sd40 || $signed(q_acc) !== 20'sd40) begin
         errors++; $display("FAIL t2_acc: i=%0d q=%0d required 40 40", $signed(i_acc), $signed(q_acc));
      end
      release_result;
   endtask

   task automatic test_saturation;
      int lat;
      set_cal(9'h100, 9'h000, 9'h0FF, 9'h000, 9'h000, 9'h000);
      start_win(10'd16);
      for (int k = 0; k < 16; k++) send(9'd255, 9'd0);
      wait_done(lat);
      checks++;
      if ($signed(i_acc) !== 20'sd4064 || overflow !== 1'b0) begin
         errors++; $display("FAIL t3_wide: i=%0d ovf=%b required 4064 0", $signed(i_acc), overflow);
      end
      checks++;
      if (i12 !== 12'h7FF || ovf12 !== 1'b1) begin
         errors++; $display("FAIL t3_narrow: i=%0d ovf=%b required 2047 1", $signed(i12), ovf12);
      end
      release_result;
      checks++;
      if (ovf12 !== 1'b1 || busy12 !== 1'b0) begin
         errors++; $display("FAIL t3_ovf_hold: ovf=%b busy=%b required 1 0", ovf12, busy12);
      end
   endtask

   task automatic test_gaps;
      int lat;
      set_cal(9'h000, 9'h000, 9'h080, 9'h000, 9'h080, 9'h000);
      start_win(10'd0);
      checks++;
      if (ovf12 !== 1'b0 || busy12 !== 1'b1) begin
         errors++; $display("FAIL t4_ovf_clear: ovf=%b busy=%b required 0 1", ovf12, busy12);
      end
      repeat (2) @(negedge clk);
      send(9'sd60, 9'sd6);
      send(9'sd100, 9'sd100);
      send(9'sd100, 9'sd100);
      wait_done(lat);
      checks++;
      if ($signed(i_acc) !== 20'sd30 || $signed(q_acc) !== 20'sd3) begin
         errors++; $display("FAIL t4_zero_win: i=%0d q=%0d required 30 3", $signed(i_acc), $signed(q_acc));
      end
      release_result;
      start_win(10'd3);
      send(9'sd20, 9'sd2);
      @(negedge clk);
      send(9'sd40, 9'sd4);
      repeat (2) @(negedge clk);
      send(9'sd80, 9'sd8);
      send(9'sd100, 9'sd100);
      wait_done(lat);
      checks++;
      if ($signed(i_acc) !== 20'sd70 || $signed(q_acc) !== 20'sd7) begin
         errors++; $display("FAIL t4_bubbles: i=%0d q=%0d required 70 7", $signed(i_acc), $signed(q_acc));
      end
      release_result;
   endtask

   task automatic test_backpressure;
      int lat;
      ready_in = 1'b0;
      start_win(10'd2);
      for (int k = 0; k < 2; k++) send(-9'sd40, 9'sd10);
      wait_done(lat);
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (valid_out !== 1'b1 || busy !== 1'b1 || $signed(i_acc) !== -20'sd40 || $signed(q_acc) !== 20'sd10) begin
            errors++; $display("FAIL t5_hold%0d: valid=%b busy=%b i=%0d q=%0d required 1 1 -40 10",
                               k, valid_out, busy, $signed(i_acc), $signed(q_acc));
         end
      end
      ready_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ready_in = 1'b0;
      checks++;
      if (busy !== 1'b0 || valid_out !== 1'b0 || $signed(i_acc) !== -20'sd40) begin
         errors++; $display("FAIL t5_release: busy=%b valid=%b i=%0d required 0 0 -40", busy, valid_out, $signed(i_acc));
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL t5_no_queue: busy=%b required 0", busy); end
   endtask

   task automatic test_reset_mid_run;
      int lat;
      ready_in = 1'b1;
      start_win(10'd4);
      send(9'sd100, -9'sd20);
      send(9'sd100, -9'sd20);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, valid_out, overflow} !== 3'b000 || i_acc !== 20'd0 || q_acc !== 20'd0) begin
         errors++; $display("FAIL t6_reset: busy/valid/ovf=%b i=%0d q=%0d required 000 0 0",
                            {busy, valid_out, overflow}, $signed(i_acc), $signed(q_acc));
      end
      rst = 1'b0;
      @(negedge clk);
      start_win(10'd4);
      for (int k = 0; k < 4; k++) send(9'sd20, 9'sd2);
      wait_done(lat);
      checks++;
      if ($signed(i_acc) !== 20'sd40 || $signed(q_acc) !== 20'sd4 || lat != 4) begin
         errors++; $display("FAIL t6_after: i=%0d q=%0d lat=%0d required 40 4 4", $signed(i_acc), $signed(q_acc), lat);
      end
      @(negedge clk);
      ready_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; i_in = '0; q_in = '0; valid_in = 1'b0; start = 1'b0; ready_in = 1'b0;
      window_len = '0;
      set_cal(9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000);
      @(negedge clk);
      test_reset;
      test_unity_gain;
      test_dc_cross;
      test_saturation;
      test_gaps;
      test_backpressure;
      test_reset_mid_run;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
